muldiv_seq_ctrl: RTL and testbench
==================================

// Module: muldiv_seq_ctrl
// PURPOSE
//  Sequencer for the RV32M operations. Pipelined multiply with fixed latency; iterative radix-2 divide/remainder.
//  Sits beside the EX-stage ALU: the core issues one M op with start, stalls on busy, and captures result on done.
//  Single op in flight.
// PARAMETERS
//  XLEN     32  operand/result width
//  MUL_LAT  2   multiply latency in cycles from the start cycle to done (legal range 1..4)
// PORTS
//  clk      in   1     clock, rising edge
//  rst_n    in   1     asynchronous active-low reset
//  start    in   1     issue request; sampled only when accepting (see BEHAVIOUR)
//  op       in   5     ALU_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU codes from definitions.v
//  rs1      in   XLEN  operand 1 (dividend / multiplicand)
//  rs2      in   XLEN  operand 2 (divisor / multiplier)
//  flush    in   1     abort the in-flight op (pipeline kill)
//  busy     out  1     op in flight; core must hold the issuing instruction
//  done     out  1     one-cycle pulse; result valid this cycle
//  result   out  XLEN  registered result; holds until the next done
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, iteration counter=0. An async assert mid-op discards the op.
//  States:
//   IDLE: waits for start.
//   MUL: counts MUL_LAT-1 cycles.
//   DIV: runs XLEN shift/subtract iterations.
//   FIX: applies the sign fix.
//   DONE: lasts one cycle.
//  Accept: start=1 with state IDLE or DONE and flush=0. Operands and op are latched at the accepting edge.
//   start is ignored in MUL/DIV/FIX; no queueing.
//  Timing, with start accepted in cycle T:
//   MUL*: done in cycle T+MUL_LAT.
//   DIV*/REM*, special case: done in cycle T+1.
//   DIV*/REM*, normal: done in cycle T+XLEN+2 (XLEN iteration cycles, then 1 FIX cycle).
//  busy=1 from cycle T+1 through the cycle before done. busy=0 in the done cycle, so back-to-back issue is possible.
//  Multiply: full 2*XLEN product.
//   MUL returns the low half.
//   MULH: signed x signed, high half.
//   MULHSU: signed rs1 x unsigned rs2, high half.
//   MULHU: unsigned x unsigned, high half.
//  Divide: restoring algorithm on magnitudes (|rs1|, |rs2| for signed ops). Quotient is negated if the operand signs differ.
//   Remainder takes the sign of the dividend.
//  Special cases, detected at accept (no iterations):
//   rs2=0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//   Signed rs1=0x80000000 with rs2=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
//  flush=1 in any non-IDLE state: state goes to IDLE next edge. No done for the aborted op; result is unchanged.
//   flush with start in the same cycle: flush wins and start is dropped.
//   flush in the cycle a done is produced: the done pulse still occurs (the op has already retired).
//  Counter wraps never: the iteration counter saturates at XLEN-1 and is cleared on accept.
//  No combinational path from start/op/rs* to any output; all outputs are registered.
// TESTING
//  1) MUL 7*6, MUL_LAT=2, start in cycle T -> done=1 in T+2 only, result=42, busy=1 in T+1.
//  2) MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU 100*0xFFFFFFFF -> 99.
//     MULH -1*-1 -> 0.
//  3) DIV -20/5 -> done in T+34, result 0xFFFFFFFC, busy high T+1..T+33.
//     REM -20%6 -> 0xFFFFFFFE.
//     DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
//  4) Special cases, each with done in T+1 and busy never high:
//     DIV 100/0 -> 0xFFFFFFFF.
//     REMU 456/0 -> 456.
//     DIV 0x80000000/-1 -> 0x80000000.
//     REM 0x80000000%-1 -> 0.
//  5) DIVU 100/7 started, start pulsed again at T+5 with other operands -> ignored, single done at T+34, result 14.
//     Then flush at T+10 of a new DIV -> no done, busy=0 at T+11, next start accepted.
//  6) rst_n low at T+12 of a DIV -> busy=0, done=0, result=0 immediately.
//     After release, MUL 1000*2000 -> 2000000.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
// RV32M sequencer: fixed-latency multiply and iterative restoring divide/remainder.
// One op in flight; busy/done/result are all registered.
module muldiv_seq_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W    = $clog2(XLEN);
  localparam int unsigned MUL_LAST = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept_c;
  logic              a_neg_c, b_neg_c;
  logic [XLEN-1:0]   a_mag_c, b_mag_c;
  logic [XLEN:0]     shifted_c, diff_c;
  logic [XLEN-1:0]   fix_val_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // f: 0=MUL (low half), 1=MULH, 2=MULHSU, 3=MULHU
  function automatic logic [XLEN-1:0] mul_calc(input logic [1:0] f,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ax, bx, p;
    ax = ((f == 2'd1) || (f == 2'd2)) && a[XLEN-1] ? {{XLEN{1'b1}}, a} : {{XLEN{1'b0}}, a};
    bx = (f == 2'd1) && b[XLEN-1] ? {{XLEN{1'b1}}, b} : {{XLEN{1'b0}}, b};
    p  = ax * bx;
    return (f == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign accept_c  = start && !flush && (op[4:3] == 2'b10) &&
                     ((state_q == S_IDLE) || (state_q == S_DONE));
  // op[0]=1 marks the unsigned divide variants
  assign a_neg_c   = !op[0] && rs1[XLEN-1];
  assign b_neg_c   = !op[0] && rs2[XLEN-1];
  assign a_mag_c   = a_neg_c ? (~rs1 + XLEN'(1)) : rs1;
  assign b_mag_c   = b_neg_c ? (~rs2 + XLEN'(1)) : rs2;
  assign shifted_c = {rem_q, a_q[XLEN-1]};
  assign diff_c    = shifted_c - {1'b0, b_q};
  assign fix_val_c = op_q[1] ? rem_q : a_q;
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    res_d   = res_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_c) begin
          cnt_d = '0;
          op_d  = op[1:0];
          if (!op[2]) begin
            a_d = rs1;
            b_d = rs2;
            if (MUL_LAT == 1) begin
              res_d   = mul_calc(op[1:0], rs1, rs2);
              state_d = S_DONE;
            end else begin
              state_d = S_MUL;
            end
          end else if (rs2 == '0) begin
            res_d   = op[1] ? rs1 : '1;
            state_d = S_DONE;
          end else if (!op[0] && (rs1 == INT_MIN) && (rs2 == '1)) begin
            res_d   = op[1] ? '0 : rs1;
            state_d = S_DONE;
          end else begin
            a_d     = a_mag_c;
            b_d     = b_mag_c;
            rem_d   = '0;
            neg_d   = op[1] ? a_neg_c : (a_neg_c ^ b_neg_c);
            state_d = S_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(MUL_LAST)) begin
          res_d   = mul_calc(op_q, a_q, b_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_DIV: begin
        // restoring step: quotient bits shift into a_q as the dividend shifts out
        if (!diff_c[XLEN]) begin
          rem_d = diff_c[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted_c[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == CNT_MAX) state_d = S_FIX;
        else                  cnt_d   = cnt_inc_c;
      end
      S_FIX: begin
        res_d   = neg_q ? (~fix_val_c + XLEN'(1)) : fix_val_c;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // a flushed op never retires, so its result must not land
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end

    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: directed RV32M vectors, randomized ops
// against an arithmetic reference model, and start/flush/reset protocol scenarios.
module tb_muldiv_seq_ctrl;

  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 34;

  logic        clk, rst_n, start, flush, busy, done;
  logic [4:0]  op;
  logic [31:0] rs1, rs2, result;
  int checks = 0;
  int failures = 0;

  muldiv_seq_ctrl #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  // Reference: RV32M semantics with 64-bit arithmetic
  function automatic logic [31:0] model_res(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'sd0;
    case (o)
      OP_MUL:    p = sa * sb;
      OP_MULH:   begin p = sa * sb; p = p >>> 32; end
      OP_MULHSU: begin p = sa * ub; p = p >>> 32; end
      OP_MULHU:  begin p = ua * ub; p = p >> 32; end
      OP_DIV:    p = (b == 0) ? -64'sd1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb;
      OP_DIVU:   p = (b == 0) ? -64'sd1 : ua / ub;
      OP_REM:    p = (b == 0) ? sa : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 64'sd0 : sa % sb;
      OP_REMU:   p = (b == 0) ? ua : ua % ub;
      default:   p = 64'sd0;
    endcase
    return p[31:0];
  endfunction

  function automatic int model_lat(input logic [4:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    if (!o[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and measures it; lat=0 means no done within the cycle budget.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output bit busy_ok);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    lat = 0; res = 'x; busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        lat = k; res = result;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b result=%h required 0/0/0", busy, done, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_directed();
    vec_t v[11] = '{
      '{OP_MUL,    32'd7,          32'd6,          32'd42,         MUL_LAT},
      '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT},
      '{OP_MULHSU, 32'd100,        32'hFFFF_FFFF,  32'd99,         MUL_LAT},
      '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          MUL_LAT},
      '{OP_DIV,    32'hFFFF_FFEC,  32'd5,          32'hFFFF_FFFC,  DIV_LAT},
      '{OP_REM,    32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFE,  DIV_LAT},
      '{OP_DIVU,   32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  DIV_LAT},
      '{OP_DIV,    32'd100,        32'd0,          32'hFFFF_FFFF,  1},
      '{OP_REMU,   32'd456,        32'd0,          32'd456,        1},
      '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
      '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1}
    };
    int lat; logic [31:0] res; bit bok;
    foreach (v[i]) begin
      run_op(v[i].o, v[i].a, v[i].b, lat, res, bok);
      checks++;
      if (lat !== v[i].lat || res !== v[i].r || !bok) begin
        failures++;
        $display("FAIL directed[%0d] op=%h lat=%0d res=%h busy_ok=%0b required lat=%0d res=%h busy_ok=1",
                 i, v[i].o, lat, res, bok, v[i].lat, v[i].r);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result !== v[i].r) begin
        failures++;
        $display("FAIL directed_hold[%0d] done=%b result=%h required done=0 result=%h",
                 i, done, result, v[i].r);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res, a, b; logic [4:0] o; bit bok;
    for (int n = 0; n < 40; n++) begin
      o = {2'b10, 3'($urandom_range(0, 7))};
      a = rand_operand();
      b = rand_operand();
      run_op(o, a, b, lat, res, bok);
      checks++;
      if (lat !== model_lat(o, a, b) || res !== model_res(o, a, b) || !bok) begin
        failures++;
        $display("FAIL random[%0d] op=%h a=%h b=%h lat=%0d res=%h busy_ok=%0b required lat=%0d res=%h",
                 n, o, a, b, lat, res, bok, model_lat(o, a, b), model_res(o, a, b));
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0; int first = 0; logic [31:0] res = '0;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 5) begin start = 1'b1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd3; end
      else start = 1'b0;
      if (done) begin ndone++; if (first == 0) begin first = k; res = result; end end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || first !== DIV_LAT || res !== 32'd14) begin
      failures++;
      $display("FAIL ignore_start dones=%0d at=%0d res=%0d required dones=1 at=%0d res=14",
               ndone, first, res, DIV_LAT);
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res, held; bit bok; bit bad = 1'b0;
    held = result;
    @(negedge clk);
    start = 1'b1; op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (k == 10);
      if (k == 11) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL flush_busy busy=%b required 0", busy);
        end
      end
      if (done || result !== held) bad = 1'b1;
    end
    flush = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL flush_no_done saw done or result change, result=%h required %h", result, held);
    end
    run_op(OP_MUL, 32'd5, 32'd5, lat, res, bok);
    checks++;
    if (lat !== MUL_LAT || res !== 32'd25 || !bok) begin
      failures++;
      $display("FAIL flush_restart lat=%0d res=%0d required lat=%0d res=25", lat, res, MUL_LAT);
    end
    // flush beats start in the same cycle
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MUL; rs1 = 32'd2; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (busy || done || result !== 32'd25) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL flush_with_start op was accepted, result=%0d required 25 and no busy/done", result);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] o1, o2; logic [31:0] a1, b1, a2, b2, r1; int lat2;
    for (int n = 0; n < 6; n++) begin
      o1 = {2'b10, 3'($urandom_range(0, 7))}; a1 = rand_operand(); b1 = rand_operand();
      o2 = {2'b10, 3'($urandom_range(0, 7))}; a2 = rand_operand(); b2 = rand_operand();
      @(negedge clk);
      start = 1'b1; op = o1; rs1 = a1; rs2 = b1;
      @(negedge clk);
      start = 1'b0;
      r1 = 'x;
      for (int k = 1; k <= 60; k++) begin
        if (done) begin r1 = result; break; end
        @(negedge clk);
      end
      start = 1'b1; op = o2; rs1 = a2; rs2 = b2;
      @(negedge clk);
      start = 1'b0;
      lat2 = 0;
      for (int k = 1; k <= 60; k++) begin
        if (done) begin lat2 = k; break; end
        @(negedge clk);
      end
      checks++;
      if (r1 !== model_res(o1, a1, b1) || lat2 !== model_lat(o2, a2, b2) ||
          result !== model_res(o2, a2, b2)) begin
        failures++;
        $display("FAIL back_to_back[%0d] r1=%h r2=%h lat2=%0d required r1=%h r2=%h lat2=%0d",
                 n, r1, result, lat2, model_res(o1, a1, b1), model_res(o2, a2, b2),
                 model_lat(o2, a2, b2));
      end
    end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] res; bit bok;
    @(negedge clk);
    start = 1'b1; op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL async_reset busy=%b done=%b result=%h required 0/0/0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MUL, 32'd1000, 32'd2000, lat, res, bok);
    checks++;
    if (lat !== MUL_LAT || res !== 32'd2000000 || !bok) begin
      failures++;
      $display("FAIL after_reset_mul lat=%0d res=%0d required lat=%0d res=2000000", lat, res, MUL_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
